arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Client-side agent for the 5-way priority arbiter's req/gnt handshake; one instance drives each reqN/gntN pair.
- Queues transfer jobs in a small FIFO and raises req while work is pending.
- Owns the shared resource for job_len+1 cycles after gnt, then releases it with a mandatory one-cycle req-low gap so the arbiter can re-evaluate.
- Handles preemption (gnt withdrawn mid-burst) and starvation timeout.

Parameters:
- DEPTH, 4, job FIFO entries (power of 2, >=2)
- LEN_W, 4, width of job length field
- TIMEOUT, 15, max cycles in REQ without gnt before job is dropped (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered this cycle
- job_len  in  LEN_W  burst length minus one (0 = 1 owned cycle)
- job_ready  out  1  FIFO not full; job accepted when job_valid&&job_ready
- req  out  1  registered request to arbiter
- gnt  in  1  grant from arbiter, sampled on clock rising edge
- bus_own  out  1  resource owned and in use this cycle (data-phase strobe)
- xfer_done  out  1  one-cycle pulse: job completed
- timeout_err  out  1  one-cycle pulse: job dropped after TIMEOUT
- fifo_count  out  $clog2(DEPTH)+1  jobs queued, including the active one

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; FIFO empty; req=0, bus_own=0, xfer_done=0, timeout_err=0, fifo_count=0, job_ready=1. Reset mid-burst aborts immediately; the queued job is lost.
- FIFO: push on job_valid&&job_ready; pop only on job completion or timeout. A push and pop in the same cycle leave the count unchanged. Pushing while full is ignored (job_ready=0). Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, OWN, GAP.
- IDLE: if fifo_count>0, go to REQ and set req=1 next cycle. A job pushed into an empty FIFO gives req high 2 cycles after the push edge.
- REQ: req=1; the wait counter increments each cycle.
  - gnt=1: go to OWN; load remaining = head job_len (or the retained remainder after preemption); clear the wait counter.
  - Wait counter reaches TIMEOUT with gnt=0: pop, pulse timeout_err, go to GAP.
- OWN: req=1, bus_own=1. Each cycle with gnt=1 either decrements remaining, or, when remaining=0, pops, pulses xfer_done, and goes to GAP.
- Preemption: gnt=0 while in OWN gives bus_own=0 that cycle, no decrement, and a return to REQ with remaining retained. The wait counter restarts from 0.
- GAP: req=0 for exactly one cycle, then IDLE, which re-requests next cycle if jobs remain. Back-to-back jobs therefore show req low for 2 cycles between bursts.
- Simultaneous events:
  - gnt rising on the same cycle the timeout would fire: gnt wins.
  - A push during the pop cycle is accepted.
- Outputs are registered except job_ready and fifo_count, which are decoded from FIFO state.

Optional Feature:
- Macro: ARB_REQ_STATS_EN.
- When defined:
  - Adds output max_wait [7:0], the largest REQ-to-gnt latency seen, saturating at 255 and cleared by reset.
  - Adds output grant_cnt [15:0], incremented on each REQ→OWN transition and wrapping.
- When undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - FSM state enum (IDLE, REQ, OWN, GAP)
  - NUM_REQ=5
  - Default LEN_W and TIMEOUT constants
- Sub-module arb_req_fifo: synchronous DEPTH×LEN_W FIFO with push/pop/count/full/empty. The FSM lives in arb_requester.

Test Plan:
- Reset, push job_len=3, gnt tied to req → req rises 2 cycles after push; bus_own high 4 cycles; xfer_done pulse; req low 1 cycle; fifo_count 1→0.
- Push 4 jobs (len 0,1,2,0) with gnt=1 → job_ready=0 after 4th push; bursts of 1,2,3,1 cycles each separated by req-low gaps; 4 xfer_done pulses.
- gnt held 0 → after 15 cycles in REQ, timeout_err pulse, job popped, req drops; no xfer_done.
- job_len=5, gnt dropped for 3 cycles after 2 owned cycles → bus_own resumes on regrant; 4 further owned cycles; total bus_own=6.
- reset asserted low mid-OWN → req, bus_own, fifo_count zero immediately (asynchronously); no pulses; a fresh push after release works normally.
- ARB_REQ_STATS_EN: gnt delayed 7 then 3 cycles → max_wait=7, grant_cnt=2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter requester slice.
package arb_pkg;

  localparam int NUM_REQ     = 5;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_requester_if.sv
// Job-side and arbiter-side handshake bundle for one arb_requester.
// Optional statistics ports appear when ARB_REQ_STATS_EN is defined.
interface arb_requester_if #(
  parameter int DEPTH = arb_pkg::DEF_DEPTH,
  parameter int LEN_W = arb_pkg::DEF_LEN_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             req;
  logic             gnt;
  logic             bus_own;
  logic             xfer_done;
  logic             timeout_err;
  logic [CNT_W-1:0] fifo_count;

`ifdef ARB_REQ_STATS_EN
  logic [7:0]       max_wait;
  logic [15:0]      grant_cnt;

  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, bus_own, xfer_done, timeout_err, fifo_count,
    output max_wait, grant_cnt
  );
  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, bus_own, xfer_done, timeout_err, fifo_count,
    input  max_wait, grant_cnt
  );
`else
  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, bus_own, xfer_done, timeout_err, fifo_count
  );
  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, bus_own, xfer_done, timeout_err, fifo_count
  );
`endif

endinterface

// File: rtl/arb_req_fifo.sv
// Job-length FIFO for arb_requester; push while full and pop while empty are ignored.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [LEN_W-1:0]       din,
  output logic [LEN_W-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client-side req/gnt agent: queues jobs, owns the resource for job_len+1 granted
// cycles, handles preemption and starvation timeout. Stats via ARB_REQ_STATS_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic           clock,
  input logic           reset,
  arb_requester_if.master bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_e       state;
  arb_state_e       next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] head_len;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             done;
  logic             tmo;
  logic             beat;

  arb_req_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.job_valid),
    .pop   (pop),
    .din   (bus.job_len),
    .dout  (head_len),
    .count (bus.fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.job_ready = !fifo_full;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    beat       = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) next_state = REQ;
      REQ: begin
        if (bus.gnt) begin
          next_state = OWN;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          pop        = 1'b1;
          tmo        = 1'b1;
          next_state = GAP;
        end
      end
      OWN: begin
        if (bus.gnt) begin
          beat = 1'b1;
          if (rem == '0) begin
            pop        = 1'b1;
            done       = 1'b1;
            next_state = GAP;
          end
        end else begin
          next_state = REQ;
        end
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Remaining length is loaded once on IDLE->REQ, so a preempted burst resumes
  // with its remainder. Outputs register this cycle's activity and trail state by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      rem             <= '0;
      bus.req         <= 1'b0;
      bus.bus_own     <= 1'b0;
      bus.xfer_done   <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == REQ && next_state == REQ) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;
      if (state == IDLE && next_state == REQ) rem <= head_len;
      else if (beat && rem != '0)             rem <= rem - 1'b1;
      bus.req         <= (state == REQ) || (state == OWN);
      bus.bus_own     <= beat;
      bus.xfer_done   <= done;
      bus.timeout_err <= tmo;
    end
  end

`ifdef ARB_REQ_STATS_EN
  logic       grant;
  logic [7:0] lat;

  always_comb begin
    grant = (state == REQ) && bus.gnt;
    lat   = (32'(wait_cnt) > 32'd255) ? 8'hFF : 8'(wait_cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.max_wait  <= '0;
      bus.grant_cnt <= '0;
    end else if (grant) begin
      bus.grant_cnt <= bus.grant_cnt + 1'b1;
      if (lat > bus.max_wait) bus.max_wait <= lat;
    end
  end
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus randomized
// traffic scored against a transaction-level queue model.
module tb_arb_requester;
  import arb_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;

  arb_requester_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: queued job lengths and observable-level bookkeeping.
  int unsigned q[$];
  int beats, streak, gap_ph, gap_size;
  int n_own, n_done, n_tmo;
  bit mon_en = 1'b0;

  task automatic model_clear();
    q.delete();
    beats = 0; streak = 0; gap_ph = 0; gap_size = 0;
  endtask

  task automatic observe();
    bit          g, take, newgap;
    int unsigned ln;
    g      = bus.gnt;
    ln     = bus.job_len;
    take   = bus.job_valid && (q.size() < DEPTH);
    newgap = 1'b0;
    if (bus.req && !bus.bus_own) streak++;
    else                         streak = 0;
    if (bus.bus_own) begin
      check("own_needs_gnt", g, 1);
      beats++; n_own++;
    end
    if (bus.xfer_done) begin
      n_done++;
      check("done_nonempty", q.size() > 0, 1);
      check("done_tmo_excl", bus.timeout_err, 0);
      if (q.size() > 0) begin
        check("burst_len", beats, q[0] + 1);
        void'(q.pop_front());
      end
      beats = 0; newgap = 1'b1;
    end
    if (bus.timeout_err) begin
      n_tmo++;
      check("tmo_nonempty", q.size() > 0, 1);
      check("tmo_streak", streak >= TIMEOUT, 1);
      if (q.size() > 0) void'(q.pop_front());
      beats = 0; newgap = 1'b1;
    end
    if (take) q.push_back(ln);
    case (gap_ph)
      1: begin
        check("gap_req1", bus.req, 0);
        check("gap_own", bus.bus_own, 0);
        gap_size = q.size(); gap_ph = 2;
      end
      2: begin check("gap_req2", bus.req, 0); gap_ph = 3; end
      3: begin check("req_after_gap", bus.req, gap_size > 0); gap_ph = 0; end
      default: ;
    endcase
    if (newgap) gap_ph = 1;
    check("fifo_count", bus.fifo_count, q.size());
    check("job_ready", bus.job_ready, q.size() < DEPTH);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (mon_en) observe();
  endtask

  task automatic step_tie();
    step();
    bus.gnt = bus.req;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, t0, done_at, tmo_at, req_hi, own_run, k, pause, own_after, seen;
    int bursts[4];
    int exp_b[4] = '{1, 2, 3, 1};
    int lens[4]  = '{0, 1, 2, 0};
    bit own_seen;
    int p;

    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.gnt       = 1'b0;
    model_clear();
    n_own = 0; n_done = 0; n_tmo = 0;

    // Reset state
    #2 reset = 1'b0;
    step(); step();
    check("rst_req", bus.req, 0);
    check("rst_own", bus.bus_own, 0);
    check("rst_done", bus.xfer_done, 0);
    check("rst_tmo", bus.timeout_err, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.job_ready, 1);
    reset  = 1'b1;
    mon_en = 1'b1;
    step();

    // Single job, len 3, gnt follows req
    bus.job_valid = 1'b1; bus.job_len = 4'd3;
    d0 = n_done; o0 = n_own;
    step_tie();
    bus.job_valid = 1'b0;
    check("t1_count_push", bus.fifo_count, 1);
    check("t1_req_e0", bus.req, 0);
    step_tie(); check("t1_req_e1", bus.req, 0);
    step_tie(); check("t1_req_e2", bus.req, 1);
    done_at = -1;
    for (int i = 3; i <= 20; i++) begin
      step_tie();
      if (bus.xfer_done) done_at = i;
    end
    check("t1_done_cycle", done_at, 7);
    check("t1_own_cycles", n_own - o0, 4);
    check("t1_done_cnt", n_done - d0, 1);
    check("t1_count_end", bus.fifo_count, 0);

    // Four back-to-back jobs fill the FIFO
    d0 = n_done;
    for (int i = 0; i < 4; i++) begin
      bus.job_valid = 1'b1; bus.job_len = LEN_W'(lens[i]);
      step_tie();
    end
    bus.job_valid = 1'b0;
    check("t2_ready_full", bus.job_ready, 0);
    check("t2_count_full", bus.fifo_count, 4);
    own_run = 0; k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      step_tie();
      if (bus.bus_own) own_run++;
      if (bus.xfer_done) begin bursts[k] = own_run; own_run = 0; k++; end
    end
    check("t2_done_cnt", k, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_burst%0d", i), bursts[i], exp_b[i]);
    for (int i = 0; i < 5; i++) step_tie();

    // Starvation timeout
    bus.gnt = 1'b0;
    d0 = n_done; t0 = n_tmo;
    bus.job_valid = 1'b1; bus.job_len = 4'd2;
    step();
    bus.job_valid = 1'b0;
    tmo_at = -1; req_hi = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      bus.gnt = 1'b0;
      if (bus.req) req_hi++;
      if (bus.timeout_err) tmo_at = i;
    end
    check("t3_tmo_cycle", tmo_at, 16);
    check("t3_req_cycles", req_hi, TIMEOUT);
    check("t3_tmo_cnt", n_tmo - t0, 1);
    check("t3_no_done", n_done - d0, 0);
    check("t3_count_end", bus.fifo_count, 0);

    // Preemption after two owned cycles
    d0 = n_done; o0 = n_own;
    bus.job_valid = 1'b1; bus.job_len = 4'd5;
    step_tie();
    bus.job_valid = 1'b0;
    own_run = 0; pause = 0; own_after = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.bus_own) begin
        own_run++;
        if (pause > 0) own_after++;
      end
      if (own_run == 2 && pause < 3) begin bus.gnt = 1'b0; pause++; end
      else                               bus.gnt = bus.req;
    end
    check("t4_own_total", n_own - o0, 6);
    check("t4_own_after", own_after, 4);
    check("t4_done_cnt", n_done - d0, 1);

    // Asynchronous reset during OWN
    bus.job_valid = 1'b1; bus.job_len = 4'd7;
    step_tie();
    bus.job_valid = 1'b0;
    own_seen = 1'b0;
    for (int i = 0; i < 10 && !own_seen; i++) begin
      step_tie();
      own_seen = bus.bus_own;
    end
    check("t5_own_seen", own_seen, 1);
    #2 reset = 1'b0;
    mon_en = 1'b0;
    bus.gnt = 1'b0;
    #1;
    check("t5_req_async", bus.req, 0);
    check("t5_own_async", bus.bus_own, 0);
    check("t5_count_async", bus.fifo_count, 0);
    check("t5_ready_async", bus.job_ready, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t5_no_done", bus.xfer_done, 0);
      check("t5_no_tmo", bus.timeout_err, 0);
    end
    reset = 1'b1;
    model_clear();
    mon_en = 1'b1;
    step();
    bus.job_valid = 1'b1; bus.job_len = 4'd0;
    step_tie();
    bus.job_valid = 1'b0;
    done_at = -1;
    for (int i = 1; i <= 15; i++) begin
      step_tie();
      if (bus.xfer_done && done_at < 0) done_at = i;
    end
    check("t5_fresh_done", done_at, 4);

`ifdef ARB_REQ_STATS_EN
    // Grant latency statistics
    mon_en = 1'b0;
    #2 reset = 1'b0;
    step();
    reset = 1'b1;
    model_clear();
    mon_en = 1'b1;
    foreach (exp_b[j]) begin
      if (j < 2) begin
        int dly;
        dly = (j == 0) ? 7 : 3;
        bus.job_valid = 1'b1; bus.job_len = 4'd0; bus.gnt = 1'b0;
        step();
        bus.job_valid = 1'b0;
        seen = 0; done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
          step();
          if (bus.req) seen++;
          bus.gnt = (seen >= dly) ? bus.req : 1'b0;
          if (bus.xfer_done) done_at = i;
        end
        check("st_done_seen", done_at >= 0, 1);
        for (int i = 0; i < 4; i++) step_tie();
      end
    end
    check("st_max_wait", bus.max_wait, 7);
    check("st_grant_cnt", bus.grant_cnt, 2);
`endif

    // Randomized traffic
    bus.gnt = 1'b0;
    d0 = n_done; t0 = n_tmo;
    for (int i = 0; i < 900; i++) begin
      step();
      p = (i < 300) ? 75 : (i < 600) ? 35 : 5;
      bus.job_valid = ($urandom_range(0, 99) < 35);
      bus.job_len   = LEN_W'($urandom_range(0, 3));
      bus.gnt       = bus.req && ($urandom_range(0, 99) < p);
    end
    bus.job_valid = 1'b0;
    for (int i = 0; i < 300 && (q.size() != 0 || gap_ph != 0); i++) step_tie();
    check("rand_drained", q.size(), 0);
    check("rand_activity", (n_done > d0) && (n_tmo > t0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
